// File: rtl/cnv_pkg.sv
// Shared fp16 field layout and sequencer state encoding for the conv-output path.
package cnv_pkg;

    localparam int unsigned FP16_W        = 16;
    localparam int unsigned FP16_SIGN_BIT = 15;
    localparam int unsigned FP16_EXP_W    = 5;
    localparam int unsigned FP16_MAN_W    = 10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/fp16_relu_nz.sv
// Combinational fp16 ReLU: any sign-set pattern (including -0 and negative NaN) becomes +0.
module fp16_relu_nz
    import cnv_pkg::*;
(
    input  logic [FP16_W-1:0] in,
    output logic [FP16_W-1:0] out,
    output logic              nz
);

    always_comb begin
        out = in[FP16_SIGN_BIT] ? '0 : in;
        nz  = |out;
    end

endmodule

// File: rtl/relu_brick_encoder.sv
// Applies ReLU to a brick-grouped fp16 stream and emits only nonzero results with offsets,
// holding one result back so the final beat of each brick can be tagged last.
module relu_brick_encoder
    import cnv_pkg::*;
#(
    parameter int unsigned BRICK_SIZE = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [15:0]                    in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [15:0]                    out_data,
    output logic [$clog2(BRICK_SIZE)-1:0]  out_offset,
    output logic                           out_last,
    output logic                           out_empty,
    output logic [$clog2(BRICK_SIZE):0]    out_nz_count
);

    localparam int unsigned OFF_W = $clog2(BRICK_SIZE);
    localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(BRICK_SIZE - 1);

    state_e             state_q;
    logic [OFF_W-1:0]   idx_q;
    logic [OFF_W:0]     nz_cnt_q;
    logic               held_valid_q;
    logic [15:0]        held_data_q;
    logic [OFF_W-1:0]   held_off_q;

    logic [15:0]        relu_data;
    logic               relu_nz;
    logic               slot_free;
    logic               accept;
    logic               at_end;
    logic [OFF_W:0]     nz_cnt_inc;

    fp16_relu_nz u_relu (
        .in  (in_data),
        .out (relu_data),
        .nz  (relu_nz)
    );

    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = (state_q == ST_RUN) && slot_free;
    assign accept     = in_valid && in_ready;
    assign at_end     = (idx_q == LAST_IDX);
    assign nz_cnt_inc = nz_cnt_q + {{OFF_W{1'b0}}, relu_nz};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            idx_q        <= '0;
            nz_cnt_q     <= '0;
            held_valid_q <= 1'b0;
            held_data_q  <= '0;
            held_off_q   <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_offset   <= '0;
            out_last     <= 1'b0;
            out_empty    <= 1'b0;
            out_nz_count <= '0;
        end else begin
            // Drained beat with nothing new to load; later assignments override on emit.
            if (slot_free) begin
                out_valid <= 1'b0;
            end
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        idx_q <= idx_q + 1'b1;
                        if (!at_end) begin
                            nz_cnt_q <= nz_cnt_inc;
                            if (relu_nz) begin
                                if (held_valid_q) begin
                                    out_valid    <= 1'b1;
                                    out_data     <= held_data_q;
                                    out_offset   <= held_off_q;
                                    out_last     <= 1'b0;
                                    out_empty    <= 1'b0;
                                    out_nz_count <= '0;
                                end
                                held_valid_q <= 1'b1;
                                held_data_q  <= relu_data;
                                held_off_q   <= idx_q;
                            end
                        end else begin
                            nz_cnt_q  <= '0;
                            out_valid <= 1'b1;
                            out_empty <= 1'b0;
                            if (relu_nz && held_valid_q) begin
                                // Two results still owed: send the older now, the newer in FLUSH.
                                out_data     <= held_data_q;
                                out_offset   <= held_off_q;
                                out_last     <= 1'b0;
                                out_nz_count <= '0;
                                held_data_q  <= relu_data;
                                held_off_q   <= idx_q;
                                nz_cnt_q     <= nz_cnt_inc;
                                state_q      <= ST_FLUSH;
                            end else if (relu_nz) begin
                                out_data     <= relu_data;
                                out_offset   <= idx_q;
                                out_last     <= 1'b1;
                                out_nz_count <= nz_cnt_inc;
                            end else if (held_valid_q) begin
                                out_data     <= held_data_q;
                                out_offset   <= held_off_q;
                                out_last     <= 1'b1;
                                out_nz_count <= nz_cnt_inc;
                                held_valid_q <= 1'b0;
                            end else begin
                                out_data     <= '0;
                                out_offset   <= '0;
                                out_last     <= 1'b1;
                                out_empty    <= 1'b1;
                                out_nz_count <= '0;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (slot_free) begin
                        out_valid    <= 1'b1;
                        out_data     <= held_data_q;
                        out_offset   <= held_off_q;
                        out_last     <= 1'b1;
                        out_empty    <= 1'b0;
                        out_nz_count <= nz_cnt_q;
                        held_valid_q <= 1'b0;
                        nz_cnt_q     <= '0;
                        state_q      <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule
